rgb565_grayscale_seq: RTL and testbench
=======================================

// Module: rgb565_grayscale_seq
// PURPOSE
//  Sequential, parametrised RGB565->8-bit grayscale custom instruction for the CPU CI port.
//  Converts four packed RGB565 pixels (two per operand) to four packed grayscale bytes.
//  Time-multiplexes PIX_PER_CYCLE datapath lanes over 4/PIX_PER_CYCLE cycles.
//  Weights, instruction ID and datapath width are set at elaboration time.
// PARAMETERS
//  customInstructionID  8'd0  CI ID this block answers to
//  PIX_PER_CYCLE        4     lanes per cycle; legal 1, 2, 4 (elaboration error otherwise)
//  R_COEF               54    red weight, 8-bit unsigned
//  G_COEF               183   green weight, 8-bit unsigned
//  B_COEF               19    blue weight, 8-bit unsigned
// PORTS
//  clock   in   1   system clock, all state on rising edge
//  reset   in   1   asynchronous, active-low reset (0 = reset)
//  start   in   1   CI start strobe, one cycle
//  isId    in   8   CI ID; operation accepted only when isId == customInstructionID
//  valueA  in   32  pixels 0 ([15:0]) and 1 ([31:16]), RGB565
//  valueB  in   32  pixels 2 ([15:0]) and 3 ([31:16]), RGB565
//  done    out  1   one-cycle completion pulse
//  result  out  32  {gray3,gray2,gray1,gray0}; 0 whenever done == 0
// BEHAVIOUR
//  Reset: state IDLE, counter 0, done 0, result 0, operand/result registers 0; asserts on reset
//   falling edge, no clock needed. Reset mid-operation aborts it; no done pulse follows.
//  FSM: IDLE -> CALC on edge with start && isId match (valueA/valueB captured into registers).
//   CALC: each cycle converts PIX_PER_CYCLE pixels, index = cnt*PIX_PER_CYCLE .. +PIX_PER_CYCLE-1,
//   writes bytes into result register; cnt wraps 0..(4/PIX_PER_CYCLE)-1.
//   CALC -> DONE after last slice; DONE drives done=1 and result for exactly one cycle -> IDLE.
//  Latency: start sampled at edge k; done high in the cycle after edge k+4/PIX_PER_CYCLE
//   (P=4: 1 cycle, P=2: 2, P=1: 4). No further dead cycles; new start accepted in DONE cycle's
//   following edge (IDLE).
//  start while in CALC or DONE: ignored, no effect on running op. start with wrong isId: ignored.
//  Per pixel: r8={p[15:11],3'b0}, g8={p[10:5],2'b0}, b8={p[4:0],3'b0}.
//   sum = r8*R_COEF + g8*G_COEF + b8*B_COEF in 18 bits (no overflow for 8-bit weights).
//   gray = sum >> 8, saturated to 8'hFF if sum >> 8 exceeds 255.
//  Operands are captured once; valueA/valueB changes after the start edge do not affect result.
// CONFIGURATION
//  GRAY_ROUND_EN defined: sum += 128 before >>8 (round-half-up), then saturate.
//  GRAY_ROUND_EN undefined: truncation (sum >> 8), bit-exact with the legacy combinational CI.
// TESTING
//  T1 P=4, start, A=32'h0000_0000, B=32'h0000_0000 -> done 1 cycle after start, result 32'h0.
//  T2 A=32'hFFFF_FFFF, B=32'hFFFF_FFFF -> result 32'hFAFA_FAFA; with GRAY_ROUND_EN 32'hFBFB_FBFB.
//  T3 A=32'h07E0_F800, B=32'hFFFF_001F -> result 32'hFA12_B434 for P=1,2,4; done at 4/2/1 cycles.
//  T4 start with isId != customInstructionID -> done stays 0, result 0; second start during CALC
//   (P=1) -> single done pulse, result from first operands only.
//  T5 reset low mid-CALC (P=1, cycle 2) -> done, result 0 immediately; no done after release;
//   next valid start completes normally.
//  T6 R_COEF=G_COEF=B_COEF=255, A=32'hFFFF -> gray0 saturates to 8'hFF; done/result==0 when idle.

Source files
------------

// File: rtl/rgb565_grayscale_seq.sv
// rgb565_grayscale_seq: sequential RGB565 -> 8-bit grayscale custom instruction.
// Four packed RGB565 pixels ({valueB, valueA}) become four packed gray bytes.
// PIX_PER_CYCLE datapath lanes are time-multiplexed over 4/PIX_PER_CYCLE cycles.
// Optional macro GRAY_ROUND_EN: round-half-up before the >>8 instead of truncating.
module rgb565_grayscale_seq #(
  parameter logic [7:0] customInstructionID = 8'd0,
  parameter int         PIX_PER_CYCLE       = 4,
  parameter int         R_COEF              = 54,
  parameter int         G_COEF              = 183,
  parameter int         B_COEF              = 19
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  isId,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  output logic        done,
  output logic [31:0] result
);

  if (!(PIX_PER_CYCLE == 1 || PIX_PER_CYCLE == 2 || PIX_PER_CYCLE == 4)) begin : g_bad_lanes
    $error("rgb565_grayscale_seq: PIX_PER_CYCLE must be 1, 2 or 4");
  end

  localparam int         N_SLICE  = (PIX_PER_CYCLE > 0) ? (4 / PIX_PER_CYCLE) : 1;
  localparam logic [1:0] CNT_LAST = 2'(N_SLICE - 1);
  localparam logic [7:0] RC       = 8'(R_COEF);
  localparam logic [7:0] GC       = 8'(G_COEF);
  localparam logic [7:0] BC       = 8'(B_COEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [3:0][15:0] op_q, op_d;
  logic [3:0][7:0]  res_q, res_d;

  // Optional round-half-up bias applied ahead of the >>8.
  function automatic logic [17:0] round_sum(input logic [17:0] s);
`ifdef GRAY_ROUND_EN
    return s + 18'd128;
`else
    return s;
`endif
  endfunction

  // Clamp the scaled sum to one byte; anything at or above 256<<8 is white.
  function automatic logic [7:0] sat8(input logic [17:0] s);
    return (s[17:16] != 2'b00) ? 8'hFF : s[15:8];
  endfunction

  // Expand RGB565 channels to 8 bits and form the weighted luminance byte.
  function automatic logic [7:0] pix_gray(input logic [15:0] p);
    logic [17:0] r8, g8, b8, sum;
    r8  = 18'({p[15:11], 3'b000});
    g8  = 18'({p[10:5], 2'b00});
    b8  = 18'({p[4:0], 3'b000});
    sum = r8 * 18'(RC) + g8 * 18'(GC) + b8 * 18'(BC);
    return sat8(round_sum(sum));
  endfunction

  // State, slice counter, captured operands and result bytes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      res_q   <= res_d;
    end
  end

  // Next-state, slice datapath and output decode.
  always_comb begin
    logic [1:0] idx;
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    res_d   = res_q;
    done    = 1'b0;
    result  = '0;
    idx     = '0;
    case (state_q)
      IDLE: begin
        if (start && (isId == customInstructionID)) begin
          op_d    = {valueB, valueA};
          cnt_d   = '0;
          res_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        for (int l = 0; l < PIX_PER_CYCLE; l++) begin
          idx        = 2'(int'(cnt_q) * PIX_PER_CYCLE + l);
          res_d[idx] = pix_gray(op_q[idx]);
        end
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      DONE: begin
        done    = 1'b1;
        result  = res_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rgb565_grayscale_seq.sv
// Scoreboard bench for rgb565_grayscale_seq: four instances (P=4, P=2, P=1 with
// default weights, and P=4 with all weights 255) share the same stimulus.
module tb_rgb565_grayscale_seq;

  localparam logic [7:0] ID = 8'h5A;
  localparam int NP [4] = '{4, 2, 1, 4};

  typedef struct {
    logic [31:0] res;
    int          due;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        start;
  logic [7:0]  isId;
  logic [31:0] valueA, valueB;
  logic        done_0, done_1, done_2, done_3;
  logic [31:0] result_0, result_1, result_2, result_3;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb [4][$];

  rgb565_grayscale_seq #(.customInstructionID(ID), .PIX_PER_CYCLE(4)) u_p4 (
    .clock(clock), .reset(reset), .start(start), .isId(isId),
    .valueA(valueA), .valueB(valueB), .done(done_0), .result(result_0));
  rgb565_grayscale_seq #(.customInstructionID(ID), .PIX_PER_CYCLE(2)) u_p2 (
    .clock(clock), .reset(reset), .start(start), .isId(isId),
    .valueA(valueA), .valueB(valueB), .done(done_1), .result(result_1));
  rgb565_grayscale_seq #(.customInstructionID(ID), .PIX_PER_CYCLE(1)) u_p1 (
    .clock(clock), .reset(reset), .start(start), .isId(isId),
    .valueA(valueA), .valueB(valueB), .done(done_2), .result(result_2));
  rgb565_grayscale_seq #(.customInstructionID(ID), .PIX_PER_CYCLE(4),
                         .R_COEF(255), .G_COEF(255), .B_COEF(255)) u_sat (
    .clock(clock), .reset(reset), .start(start), .isId(isId),
    .valueA(valueA), .valueB(valueB), .done(done_3), .result(result_3));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // Reference: weighted luminance of each expanded pixel, divided by 256, clamped.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input int rc, input int gc, input int bc);
    logic [63:0] all;
    logic [15:0] p;
    logic [31:0] out;
    int r, g, bl, s, q;
    all = {b, a};
    out = '0;
    for (int i = 0; i < 4; i++) begin
      p  = all[16*i +: 16];
      r  = int'(p[15:11]) * 8;
      g  = int'(p[10:5]) * 4;
      bl = int'(p[4:0]) * 8;
      s  = r * rc + g * gc + bl * bc;
`ifdef GRAY_ROUND_EN
      s  = s + 128;
`endif
      q  = s / 256;
      if (q > 255) q = 255;
      out[8*i +: 8] = 8'(q);
    end
    return out;
  endfunction

  // Monitor: pop expectations on done, require quiet outputs otherwise.
  always @(negedge clock) begin
    logic        dn [4];
    logic [31:0] rs [4];
    exp_t        e;
    dn = '{done_0, done_1, done_2, done_3};
    rs = '{result_0, result_1, result_2, result_3};
    for (int d = 0; d < 4; d++) begin
      if (!reset) begin
        checks++;
        if (dn[d] !== 1'b0 || rs[d] !== 32'h0) begin
          errors++;
          $display("FAIL in_reset dut%0d done=%b result=%h required done=0 result=0", d, dn[d], rs[d]);
        end
      end else if (dn[d] === 1'b1) begin
        checks++;
        if (sb[d].size() == 0) begin
          errors++;
          $display("FAIL unexpected_done dut%0d cyc=%0d result=%h", d, cyc, rs[d]);
        end else begin
          e = sb[d].pop_front();
          checks++;
          if (rs[d] !== e.res) begin
            errors++;
            $display("FAIL result dut%0d got=%h required=%h", d, rs[d], e.res);
          end
          checks++;
          if (cyc != e.due) begin
            errors++;
            $display("FAIL latency dut%0d done_at=%0d required=%0d", d, cyc, e.due);
          end
        end
      end else begin
        checks++;
        if (rs[d] !== 32'h0 || dn[d] !== 1'b0) begin
          errors++;
          $display("FAIL idle_out dut%0d done=%b result=%h required 0", d, dn[d], rs[d]);
        end
        if (sb[d].size() != 0 && sb[d][0].due < cyc) begin
          e = sb[d].pop_front();
          checks++;
          errors++;
          $display("FAIL missing_done dut%0d due=%0d now=%0d required result=%h", d, e.due, cyc, e.res);
        end
      end
    end
  end

  // Drive one start strobe; expectations are queued only when it should be accepted.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [7:0] id,
                       input bit acc, input logic [31:0] e_def, input logic [31:0] e_sat);
    exp_t e;
    valueA = a;
    valueB = b;
    isId   = id;
    start  = 1'b1;
    if (acc) begin
      for (int d = 0; d < 4; d++) begin
        e.res = (d == 3) ? e_sat : e_def;
        e.due = cyc + 1 + 4 / NP[d];
        sb[d].push_back(e);
      end
    end
    @(negedge clock);
    start  = 1'b0;
    valueA = $urandom;
    valueB = $urandom;
    isId   = 8'($urandom);
  endtask

  task automatic issue_model(input logic [31:0] a, input logic [31:0] b);
    issue(a, b, ID, 1'b1, model(a, b, 54, 183, 19), model(a, b, 255, 255, 255));
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check_quiet(input string nm);
    logic        dn [4];
    logic [31:0] rs [4];
    dn = '{done_0, done_1, done_2, done_3};
    rs = '{result_0, result_1, result_2, result_3};
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (dn[d] !== 1'b0 || rs[d] !== 32'h0) begin
        errors++;
        $display("FAIL %s dut%0d done=%b result=%h required done=0 result=0", nm, d, dn[d], rs[d]);
      end
    end
  endtask

  initial begin
    logic [31:0] a, b;
    start  = 1'b0;
    isId   = 8'h00;
    valueA = '0;
    valueB = '0;
    reset  = 1'b0;
    #1;
    check_quiet("reset_state");
    gap(3);
    reset = 1'b1;
    gap(2);

    // All-black pixels.
    issue(32'h0, 32'h0, ID, 1'b1, 32'h0, 32'h0);
    gap(6);
    // All-white pixels.
`ifdef GRAY_ROUND_EN
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, ID, 1'b1, 32'hFBFB_FBFB, 32'hFFFF_FFFF);
`else
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, ID, 1'b1, 32'hFAFA_FAFA, 32'hFFFF_FFFF);
`endif
    gap(6);
    // Pure red / green / blue / white pixel mix.
`ifdef GRAY_ROUND_EN
    issue(32'h07E0_F800, 32'hFFFF_001F, ID, 1'b1, 32'hFB12_B434,
          model(32'h07E0_F800, 32'hFFFF_001F, 255, 255, 255));
`else
    issue(32'h07E0_F800, 32'hFFFF_001F, ID, 1'b1, 32'hFA12_B434,
          model(32'h07E0_F800, 32'hFFFF_001F, 255, 255, 255));
`endif
    gap(6);
    // Saturation with all weights at 255.
    issue(32'h0000_FFFF, 32'h0, ID, 1'b1,
          model(32'h0000_FFFF, 32'h0, 54, 183, 19), 32'h0000_00FF);
    gap(6);

    // Wrong instruction ID is ignored.
    issue($urandom, $urandom, ID ^ 8'h81, 1'b0, 32'h0, 32'h0);
    gap(6);

    // Extra starts while busy (CALC, then DONE for P=4) are ignored.
    issue_model(32'h1234_ABCD, 32'h8001_7FFE);
    issue($urandom, $urandom, ID, 1'b0, 32'h0, 32'h0);
    issue($urandom, $urandom, ID, 1'b0, 32'h0, 32'h0);
    gap(6);

    // Reset asserted while the P=1 instance is mid-calculation.
    issue_model(32'hDEAD_BEEF, 32'hCAFE_F00D);
    gap(2);
    #2;
    reset = 1'b0;
    for (int d = 0; d < 4; d++) sb[d].delete();
    #1;
    check_quiet("async_reset");
    gap(2);
    reset = 1'b1;
    gap(6);
    issue_model(32'h5555_AAAA, 32'h0F0F_F0F0);
    gap(6);

    // Randomised operations, occasionally with a foreign ID.
    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 4) == 0)
        issue(a, b, ID ^ 8'($urandom_range(1, 255)), 1'b0, 32'h0, 32'h0);
      else
        issue_model(a, b);
      gap(6);
    end

    gap(3);
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (sb[d].size() != 0) begin
        errors++;
        $display("FAIL leftover dut%0d pending=%0d required=0", d, sb[d].size());
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
